multireg_sequencer: RTL and testbench
=====================================

MULTIREG_SEQUENCER -- requirements
Module: multireg_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameters SHALL be: LIST_W (default 8), the register-list width; WORD_BYTES (default 4), the bytes per transfer; OFF_W (default 8), the signed offset width, which must hold ±WORD_BYTES*(LIST_W+1); SP_IDX (default 13); LR_IDX (default 14); PC_IDX (default 15).
REQ-003 Ports SHALL be, with clock and reset first:
- clk_i  in  1  clock
- rst_n_i  in  1  async active-low reset
- instr_i  in  16  Thumb instruction
- instr_valid_i  in  1  instruction offered
- ready_o  out  1  block can accept an instruction
- stall_i  in  1  downstream cannot take a micro-op
- flush_i  in  1  abort the current sequence
- uop_valid_o  out  1  micro-op valid
- uop_load_o  out  1  micro-op is a load
- uop_store_o  out  1  micro-op is a store
- uop_reg_o  out  4  data register
- uop_base_o  out  4  base register
- uop_offset_o  out  OFF_W  signed byte offset from the original base
- uop_last_o  out  1  final micro-op of the sequence
- wb_en_o  out  1  base writeback enable
- wb_delta_o  out  OFF_W  signed base adjustment
- err_o  out  1  one-cycle pulse: empty register list

Function
REQ-004 A handshake SHALL occur when instr_valid_i and ready_o are both high; ready_o SHALL be high only in state IDLE.
REQ-005 Recognised encodings SHALL be:
- PUSH: 1011_0_10_R_list
- POP: 1011_1_10_R_list
- STMIA: 1100_0_Rb_list
- LDMIA: 1100_1_Rb_list
REQ-006 Any other accepted encoding SHALL be discarded: no micro-ops, no err_o, and the block stays in IDLE.
REQ-007 For PUSH, the effective list SHALL be list plus LR_IDX when R=1; for POP, list plus PC_IDX when R=1.
REQ-008 With N = popcount of the effective list and N = 0, the block SHALL pulse err_o in the cycle after the handshake and remain in IDLE.
REQ-009 With N > 0, the block SHALL enter state ISSUE and present the first micro-op in the cycle after the handshake.
REQ-010 Micro-ops SHALL issue in ascending register-number order, one per cycle while stall_i=0; the first micro-op is k=0.
REQ-011 While stall_i=1, all uop_* outputs SHALL hold their values unchanged.
REQ-012 The k-th micro-op SHALL carry:
- PUSH: base SP_IDX, store, offset -WORD_BYTES*N + WORD_BYTES*k
- POP: base SP_IDX, load, offset WORD_BYTES*k
- STMIA/LDMIA: base Rb, store/load respectively, offset WORD_BYTES*k
REQ-013 uop_last_o and wb_en_o SHALL be asserted only together with the final micro-op.
REQ-014 wb_delta_o SHALL be:
- PUSH: -WORD_BYTES*N
- POP, STMIA, LDMIA: +WORD_BYTES*N
REQ-015 For LDMIA with Rb in the list, wb_en_o SHALL stay 0.
REQ-016 uop_load_o and uop_store_o SHALL be 0 whenever uop_valid_o=0, and never both 1.
REQ-017 The transition ISSUE->IDLE SHALL occur on the cycle the last micro-op is consumed (uop_valid_o=1, stall_i=0).
REQ-018 ready_o SHALL rise in the following cycle; there is no back-to-back acceptance in the consuming cycle.
REQ-019 flush_i=1 SHALL take priority over stall_i and over a handshake: it returns the block to IDLE next cycle, drops the remaining micro-ops and suppresses writeback.
REQ-020 A flush asserted in the cycle the last micro-op is consumed SHALL still suppress wb_en_o effects; the consumer treats flush as the kill.
REQ-021 The latched instruction and the remaining-list register SHALL change only on a handshake or when a micro-op is consumed.

Reset
REQ-022 While rst_n_i=0, the block SHALL be in IDLE with outputs: ready_o=1; all uop_* fields, wb_en_o, wb_delta_o and err_o at 0.
REQ-023 A reset asserted mid-sequence SHALL abandon the sequence immediately, with no writeback and no further micro-ops after release.
REQ-024 The first handshake SHALL be possible in the first clock edge after rst_n_i deasserts.

Verification
REQ-025 PUSH {r0,r2,LR} (0xB505), stall_i=0 -> three stores, one per cycle:
- r0 at -12, r2 at -8, r14 at -4, all with base 13
- last micro-op: wb_en_o=1, wb_delta_o=-12
- ready_o=1 one cycle after the last micro-op
REQ-026 POP {r1,PC} (0xBD02), with stall_i=1 for 2 cycles on the first micro-op -> r1 at +0 is held for 3 cycles, then r15 at +4 with uop_last_o=1 and wb_delta_o=+8.
REQ-027 LDMIA r3!,{r3,r4} (0xCB18) -> loads r3 at +0 and r4 at +4, base 3, wb_en_o=0.
REQ-028 STMIA r0!,{} (0xC000) -> err_o pulses once, no uop_valid_o, ready_o stays 1.
REQ-029 PUSH {r0-r7} with flush_i after the 3rd micro-op -> uop_valid_o=0 next cycle, no wb_en_o, ready_o=1; a following POP {r0} issues correctly.
REQ-030 Reset mid-sequence, and instr 0x1C08 (non-multi) -> reset returns outputs to the REQ-022 values; the non-multi instruction produces no micro-ops.

Source files
------------

// File: rtl/multireg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multireg_sequencer
// Brief    : Cracks Thumb PUSH/POP/STMIA/LDMIA into single-register micro-ops.
// Revision : 1.0 - initial release
// ============================================================================
module multireg_sequencer #(
    parameter int LIST_W     = 8,
    parameter int WORD_BYTES = 4,
    parameter int OFF_W      = 8,
    parameter int SP_IDX     = 13,
    parameter int LR_IDX     = 14,
    parameter int PC_IDX     = 15
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [15:0]      instr_i,
    input  logic             instr_valid_i,
    output logic             ready_o,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic             uop_valid_o,
    output logic             uop_load_o,
    output logic             uop_store_o,
    output logic [3:0]       uop_reg_o,
    output logic [3:0]       uop_base_o,
    output logic [OFF_W-1:0] uop_offset_o,
    output logic             uop_last_o,
    output logic             wb_en_o,
    output logic [OFF_W-1:0] wb_delta_o,
    output logic             err_o
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    localparam logic [1:0] K_PUSH = 2'd0;
    localparam logic [1:0] K_POP  = 2'd1;
    localparam logic [1:0] K_STM  = 2'd2;
    localparam logic [1:0] K_LDM  = 2'd3;

    localparam logic [OFF_W-1:0] C_WB = OFF_W'(WORD_BYTES);

    logic [0:0]       r_state;
    logic [15:0]      r_list;
    logic [1:0]       r_kind;
    logic [2:0]       r_rb;
    logic [4:0]       r_n;
    logic [4:0]       r_k;
    logic             r_wb_ok;
    logic             r_err;

    logic             w_is_push;
    logic             w_is_pop;
    logic             w_is_stm;
    logic             w_is_ldm;
    logic             w_known;
    logic [1:0]       w_kind;
    logic [15:0]      w_eff_list;
    logic [4:0]       w_eff_n;
    logic             w_valid;
    logic             w_last;
    logic             w_hs;
    logic             w_consume;
    logic [3:0]       w_cur_reg;
    logic [OFF_W-1:0] w_k_off;
    logic [OFF_W-1:0] w_total;

    function automatic logic [4:0] f_popcount(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'b0, v[i]};
        end
        return c;
    endfunction

    assign w_is_push = (instr_i[15:9] == 7'b1011_010);
    assign w_is_pop  = (instr_i[15:9] == 7'b1011_110);
    assign w_is_stm  = (instr_i[15:11] == 5'b1100_0);
    assign w_is_ldm  = (instr_i[15:11] == 5'b1100_1);
    assign w_known   = w_is_push | w_is_pop | w_is_stm | w_is_ldm;

    always_comb begin
        w_kind = K_LDM;
        if (w_is_push) begin
            w_kind = K_PUSH;
        end else if (w_is_pop) begin
            w_kind = K_POP;
        end else if (w_is_stm) begin
            w_kind = K_STM;
        end
    end

    // The R bit folds LR into a PUSH and PC into a POP.
    always_comb begin
        w_eff_list = 16'(instr_i[LIST_W-1:0]);
        if (w_is_push && instr_i[8]) begin
            w_eff_list[LR_IDX] = 1'b1;
        end
        if (w_is_pop && instr_i[8]) begin
            w_eff_list[PC_IDX] = 1'b1;
        end
    end

    assign w_eff_n = f_popcount(w_eff_list);

    always_comb begin
        w_cur_reg = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (r_list[i]) begin
                w_cur_reg = 4'(i);
            end
        end
    end

    assign ready_o   = (r_state == S_IDLE);
    assign w_valid   = (r_state == S_ISSUE);
    assign w_last    = ((r_list & (r_list - 16'd1)) == 16'd0);
    assign w_hs      = instr_valid_i & ready_o & ~flush_i;
    assign w_consume = w_valid & ~stall_i & ~flush_i;
    assign w_k_off   = C_WB * OFF_W'(r_k);
    assign w_total   = C_WB * OFF_W'(r_n);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_list  <= '0;
            r_kind  <= K_PUSH;
            r_rb    <= '0;
            r_n     <= '0;
            r_k     <= '0;
            r_wb_ok <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (flush_i) begin
                r_state <= S_IDLE;
            end else if (w_hs) begin
                if (w_known) begin
                    if (w_eff_n == 5'd0) begin
                        r_err <= 1'b1;
                    end else begin
                        r_state <= S_ISSUE;
                        r_list  <= w_eff_list;
                        r_kind  <= w_kind;
                        r_rb    <= instr_i[10:8];
                        r_n     <= w_eff_n;
                        r_k     <= 5'd0;
                        // LDMIA loading its own base keeps the loaded value.
                        r_wb_ok <= !(w_is_ldm && w_eff_list[instr_i[10:8]]);
                    end
                end
            end else if (w_consume) begin
                r_list <= r_list & (r_list - 16'd1);
                r_k    <= r_k + 5'd1;
                if (w_last) begin
                    r_state <= S_IDLE;
                end
            end
        end
    end

    assign err_o       = r_err;
    assign uop_valid_o = w_valid;
    assign uop_load_o  = w_valid & ((r_kind == K_POP) | (r_kind == K_LDM));
    assign uop_store_o = w_valid & ((r_kind == K_PUSH) | (r_kind == K_STM));
    assign uop_reg_o   = w_valid ? w_cur_reg : 4'd0;
    assign uop_base_o  = !w_valid ? 4'd0 :
                         ((r_kind == K_PUSH) | (r_kind == K_POP)) ? 4'(SP_IDX) : {1'b0, r_rb};
    assign uop_offset_o = !w_valid ? '0 :
                          (r_kind == K_PUSH) ? (w_k_off - w_total) : w_k_off;
    assign uop_last_o  = w_valid & w_last;
    assign wb_en_o     = w_valid & w_last & r_wb_ok & ~flush_i;
    assign wb_delta_o  = !w_valid ? '0 :
                         (r_kind == K_PUSH) ? ('0 - w_total) : w_total;

endmodule
`default_nettype wire

// File: tb/tb_multireg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multireg_sequencer
// Brief    : Cycle-vector table plus a stalled STMIA sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multireg_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [15:0] instr_i = 16'h0000;
    logic        instr_valid_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        ready_o;
    logic        uop_valid_o;
    logic        uop_load_o;
    logic        uop_store_o;
    logic [3:0]  uop_reg_o;
    logic [3:0]  uop_base_o;
    logic [7:0]  uop_offset_o;
    logic        uop_last_o;
    logic        wb_en_o;
    logic [7:0]  wb_delta_o;
    logic        err_o;

    multireg_sequencer dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .ready_o       (ready_o),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .uop_valid_o   (uop_valid_o),
        .uop_load_o    (uop_load_o),
        .uop_store_o   (uop_store_o),
        .uop_reg_o     (uop_reg_o),
        .uop_base_o    (uop_base_o),
        .uop_offset_o  (uop_offset_o),
        .uop_last_o    (uop_last_o),
        .wb_en_o       (wb_en_o),
        .wb_delta_o    (wb_delta_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected word: {ready, valid, load, store, reg, base, offset, last, wb_en, delta, err}
    typedef struct {
        logic        rst_n;
        logic [15:0] instr;
        logic        vld;
        logic        stl;
        logic        fl;
        logic [30:0] exp_o;
    } vec_t;

    vec_t tbl [40];
    int   n_vec = 0;
    int   total = 0;
    int   bad = 0;

    task automatic add(input logic rst, input logic [15:0] ins, input logic vl,
                       input logic stl, input logic fl,
                       input logic rdy, input logic v, input logic ld, input logic st,
                       input logic [3:0] rg, input logic [3:0] bs, input logic [7:0] off,
                       input logic lst, input logic wb, input logic [7:0] dl, input logic er);
        tbl[n_vec].rst_n = rst;
        tbl[n_vec].instr = ins;
        tbl[n_vec].vld   = vl;
        tbl[n_vec].stl   = stl;
        tbl[n_vec].fl    = fl;
        tbl[n_vec].exp_o = {rdy, v, ld, st, rg, bs, off, lst, wb, dl, er};
        n_vec++;
    endtask

    task automatic idle_row(input logic rst, input logic [15:0] ins, input logic vl,
                            input logic fl);
        add(rst, ins, vl, 1'b0, fl, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00,
            1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    function automatic logic [30:0] actual();
        return {ready_o, uop_valid_o, uop_load_o, uop_store_o, uop_reg_o, uop_base_o,
                uop_offset_o, uop_last_o, wb_en_o, wb_delta_o, err_o};
    endfunction

    task automatic check(input string name, input logic [30:0] got, input logic [30:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", name, got, want);
        end
    endtask

    logic [3:0]  hs_reg [3];
    logic [7:0]  hs_off [3];

    initial begin
        // reset, then PUSH {r0,r2,LR} on the first edge after release
        idle_row(1'b0, 16'h0000, 1'b0, 1'b0);
        idle_row(1'b1, 16'hB505, 1'b1, 1'b0);
        add(1, 16'h0, 0, 0, 0, 0, 1, 0, 1, 4'd0,  4'd13, 8'hF4, 0, 0, 8'hF4, 0);
        add(1, 16'h0, 0, 0, 0, 0, 1, 0, 1, 4'd2,  4'd13, 8'hF8, 0, 0, 8'hF4, 0);
        add(1, 16'h0, 0, 0, 0, 0, 1, 0, 1, 4'd14, 4'd13, 8'hFC, 1, 1, 8'hF4, 0);
        // POP {r1,PC} with two stalled cycles on r1
        idle_row(1'b1, 16'hBD02, 1'b1, 1'b0);
        add(1, 16'h0, 0, 1, 0, 0, 1, 1, 0, 4'd1,  4'd13, 8'h00, 0, 0, 8'h08, 0);
        add(1, 16'h0, 0, 1, 0, 0, 1, 1, 0, 4'd1,  4'd13, 8'h00, 0, 0, 8'h08, 0);
        add(1, 16'h0, 0, 0, 0, 0, 1, 1, 0, 4'd1,  4'd13, 8'h00, 0, 0, 8'h08, 0);
        add(1, 16'h0, 0, 0, 0, 0, 1, 1, 0, 4'd15, 4'd13, 8'h04, 1, 1, 8'h08, 0);
        // LDMIA r3!,{r3,r4}: base in list, no writeback
        idle_row(1'b1, 16'hCB18, 1'b1, 1'b0);
        add(1, 16'h0, 0, 0, 0, 0, 1, 1, 0, 4'd3,  4'd3,  8'h00, 0, 0, 8'h08, 0);
        add(1, 16'h0, 0, 0, 0, 0, 1, 1, 0, 4'd4,  4'd3,  8'h04, 1, 0, 8'h08, 0);
        // STMIA r0!,{} -> err pulse only
        idle_row(1'b1, 16'hC000, 1'b1, 1'b0);
        add(1, 16'h0, 0, 0, 0, 1, 0, 0, 0, 4'd0,  4'd0,  8'h00, 0, 0, 8'h00, 1);
        // non-multi instruction is discarded
        idle_row(1'b1, 16'h1C08, 1'b1, 1'b0);
        idle_row(1'b1, 16'h0000, 1'b0, 1'b0);
        // PUSH {r0-r7}, flush after the third micro-op, then POP {r0}
        idle_row(1'b1, 16'hB4FF, 1'b1, 1'b0);
        add(1, 16'h0, 0, 0, 0, 0, 1, 0, 1, 4'd0,  4'd13, 8'hE0, 0, 0, 8'hE0, 0);
        add(1, 16'h0, 0, 0, 0, 0, 1, 0, 1, 4'd1,  4'd13, 8'hE4, 0, 0, 8'hE0, 0);
        add(1, 16'h0, 0, 0, 0, 0, 1, 0, 1, 4'd2,  4'd13, 8'hE8, 0, 0, 8'hE0, 0);
        add(1, 16'h0, 0, 0, 1, 0, 1, 0, 1, 4'd3,  4'd13, 8'hEC, 0, 0, 8'hE0, 0);
        idle_row(1'b1, 16'hBC01, 1'b1, 1'b0);
        add(1, 16'h0, 0, 0, 0, 0, 1, 1, 0, 4'd0,  4'd13, 8'h00, 1, 1, 8'h04, 0);
        // reset mid-sequence
        idle_row(1'b1, 16'hB505, 1'b1, 1'b0);
        add(1, 16'h0, 0, 0, 0, 0, 1, 0, 1, 4'd0,  4'd13, 8'hF4, 0, 0, 8'hF4, 0);
        idle_row(1'b0, 16'h0000, 1'b0, 1'b0);
        idle_row(1'b1, 16'h0000, 1'b0, 1'b0);
        // flush on the last micro-op kills writeback; flush beats a handshake
        idle_row(1'b1, 16'hBC01, 1'b1, 1'b0);
        add(1, 16'h0, 0, 0, 1, 0, 1, 1, 0, 4'd0,  4'd13, 8'h00, 1, 0, 8'h04, 0);
        idle_row(1'b1, 16'hB505, 1'b1, 1'b1);
        idle_row(1'b1, 16'h0000, 1'b0, 1'b0);

        for (int i = 0; i < n_vec; i++) begin
            @(negedge clk_i);
            rst_n_i       = tbl[i].rst_n;
            instr_i       = tbl[i].instr;
            instr_valid_i = tbl[i].vld;
            stall_i       = tbl[i].stl;
            flush_i       = tbl[i].fl;
            #1;
            check($sformatf("vec%0d", i), actual(), tbl[i].exp_o);
        end

        // STMIA r1!,{r0,r1,r7} with alternating stalls; base in list keeps writeback
        hs_reg[0] = 4'd0; hs_reg[1] = 4'd1; hs_reg[2] = 4'd7;
        hs_off[0] = 8'h00; hs_off[1] = 8'h04; hs_off[2] = 8'h08;
        @(negedge clk_i);
        instr_i = 16'hC183; instr_valid_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        begin
            int idx;
            int cyc;
            idx = 0;
            cyc = 0;
            while (idx < 3 && cyc < 20) begin
                stall_i = (cyc % 2 == 0);
                #1;
                check($sformatf("stm_c%0d", cyc), actual(),
                      {1'b0, 1'b1, 1'b0, 1'b1, hs_reg[idx], 4'd1, hs_off[idx],
                       (idx == 2), (idx == 2), 8'h0C, 1'b0});
                if (!stall_i) idx++;
                cyc++;
                @(negedge clk_i);
            end
            stall_i = 1'b0;
            if (idx != 3) begin
                total++;
                bad++;
                $display("FAIL stm_timeout: got=%0d uops want=3", idx);
            end
            #1;
            check("stm_done", actual(), {1'b1, 30'd0});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
